alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Single-cycle integer execution unit directly downstream of the reservation station in the out-of-order RV32I core. It accepts one ready instruction per cycle (operands, immediate, PC, ROB entry) and computes the result and, for control flow, the resolved next PC and taken flag. It drives the ALU leg of the CDB one cycle later. The reservation station forwards that leg verbatim, and the ROB and load-store buffer consume it.

## Interface
- ENTRY_W, 6: ROB entry tag width; matches the codebase entry range.
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; low pauses the unit.
- roll_back  in  1  misprediction flush, synchronous.
- new_calculate  in  1  issue valid from the reservation station.
- rs_instruct_in  in  32  raw instruction; opcode [6:0], funct3 [14:12], bit 30.
- rs_vj_in  in  32  rs1 value.
- rs_vk_in  in  32  rs2 value.
- rs_imm_in  in  32  sign-extended immediate from the decoder.
- rs_pc_in  in  32  instruction PC.
- rs_entry_in  in  ENTRY_W  ROB tag.
- alu_broadcast  out  1  CDB valid, registered.
- alu_entry  out  ENTRY_W  ROB tag of the result.
- alu_value  out  32  rd write value.
- alu_pc_out  out  32  resolved next PC.
- alu_jump  out  1  control transfer taken (branch taken, JAL, JALR).

## Operation
- Decoding uses only rs_instruct_in. The op code from the reservation station is not used.
- LUI: value = imm; pc_out = pc+4; jump = 0.
- AUIPC: value = pc+imm; pc_out = pc+4; jump = 0.
- JAL: value = pc+4; pc_out = pc+imm; jump = 1.
- JALR: value = pc+4; pc_out = (vj+imm) & 32'hFFFF_FFFE; jump = 1.
- BRANCH (0x63): value = 0.
  - Condition by funct3: BEQ, BNE, BLT and BGE are signed compares; BLTU and BGEU are unsigned.
  - taken: pc_out = pc+imm, jump = 1. Not taken: pc_out = pc+4, jump = 0.
  - funct3 010 or 011: treated as not taken.
- OP-IMM (0x13): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI.
  - Shift amount = imm[4:0].
  - SRAI is selected by instruction bit 30.
  - pc_out = pc+4.
- OP (0x33): ADD/SUB (bit 30), SLL, SLT, SLTU, XOR, SRL/SRA (bit 30), OR, AND.
  - Shift amount = vk[4:0].
  - pc_out = pc+4.
- Any other opcode still broadcasts, with value 0, pc_out = pc+4, jump = 0. The ROB must never stall on a lost tag.
- All arithmetic is modulo 2^32. Overflow is ignored. SLT/SLTU results are zero-extended 0/1.
- The unit has no internal queue and no backpressure. It accepts one instruction per active cycle.

## Timing
- Reset (rst_in low, async): all outputs go to 0 immediately and stay 0 until the first active edge after release.
- Latency: new_calculate sampled high at edge N gives alu_broadcast high after edge N, with the matching entry, value, pc_out and jump, valid for exactly one cycle.
- Throughput: back-to-back issues give back-to-back broadcasts with no bubble.
- new_calculate low at an active edge: alu_broadcast goes 0. Data outputs hold their last values.
- rdy_in low: all output registers hold, including alu_broadcast, and inputs are ignored. The unit resumes on the first edge with rdy_in high.
- roll_back high at an edge: all outputs clear to 0, regardless of rdy_in and new_calculate. An instruction issued in the same cycle is discarded.
- Priority: reset > roll_back > !rdy_in > issue.

## Test plan
- Reset and flush:
  - Assert rst_in low mid-cycle with broadcast active: outputs go 0 asynchronously; after release with new_calculate = 0, alu_broadcast stays 0.
  - Issue ADD with roll_back = 1 in the same cycle: no broadcast follows.
- ALU ops: back-to-back issue of three instructions, expecting one broadcast per cycle with no gaps and tags 3, 4, 5 in order.
  - ADD vj=7, vk=5.
  - SUB vj=5, vk=7 (bit30=1).
  - SRA vj=0x80000000, vk=4.
  - Expected values 12, 0xFFFFFFFE and 0xF8000000.
- Immediates and compares:
  - SLTI vj=-1, imm=0 -> value 1.
  - SLTIU vj=0xFFFFFFFF, imm=0 -> value 0.
  - SRLI vj=0xF0, imm=4 -> value 0x0F.
- Branches at pc=0x100, imm=0x20:
  - BLT vj=-2, vk=1 -> pc_out 0x120, jump 1.
  - BLTU with the same operands -> pc_out 0x104, jump 0.
  - BEQ vj=vk=9 -> pc_out 0x120, jump 1.
- Jumps at pc=0x200:
  - JALR vj=0x1001, imm=2 -> value 0x204, pc_out 0x1002, jump 1.
  - JAL imm=-8 -> pc_out 0x1F8.
  - LUI imm=0x12345000 -> value 0x12345000.
- Pause: with rdy_in low for 3 cycles while a broadcast is active, the outputs hold unchanged. A new_calculate presented during the pause is ignored. Operation resumes on the first edge with rdy_in high.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - single-cycle RV32I integer execution unit driving the ALU CDB leg
module alu_exec_unit #(
    parameter int ENTRY_W = 6
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               roll_back,
    input  logic               new_calculate,
    input  logic [31:0]        rs_instruct_in,
    input  logic [31:0]        rs_vj_in,
    input  logic [31:0]        rs_vk_in,
    input  logic [31:0]        rs_imm_in,
    input  logic [31:0]        rs_pc_in,
    input  logic [ENTRY_W-1:0] rs_entry_in,
    output logic               alu_broadcast,
    output logic [ENTRY_W-1:0] alu_entry,
    output logic [31:0]        alu_value,
    output logic [31:0]        alu_pc_out,
    output logic               alu_jump
);

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        bit30;
    logic        is_op;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic [31:0] alu_res;
    logic        br_taken;
    logic [31:0] nxt_value;
    logic [31:0] nxt_pc;
    logic        nxt_jump;
    logic        unused_instr_bits;

    assign opcode      = rs_instruct_in[6:0];
    assign funct3      = rs_instruct_in[14:12];
    assign bit30       = rs_instruct_in[30];
    assign is_op       = (opcode == OPC_OP);
    // OP and OP-IMM share one datapath; only the second operand differs
    assign op_b        = is_op ? rs_vk_in : rs_imm_in;
    assign shamt       = op_b[4:0];
    assign pc_plus4    = rs_pc_in + 32'd4;
    assign pc_plus_imm = rs_pc_in + rs_imm_in;
    assign unused_instr_bits = ^{rs_instruct_in[31], rs_instruct_in[29:15], rs_instruct_in[11:7]};

    // Integer datapath for OP / OP-IMM; bit 30 picks SUB only for register-register ops
    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = (is_op && bit30) ? (rs_vj_in - op_b) : (rs_vj_in + op_b);
            3'b001:  alu_res = rs_vj_in << shamt;
            3'b010:  alu_res = {31'b0, ($signed(rs_vj_in) < $signed(op_b))};
            3'b011:  alu_res = {31'b0, (rs_vj_in < op_b)};
            3'b100:  alu_res = rs_vj_in ^ op_b;
            3'b101:  alu_res = bit30 ? $unsigned($signed(rs_vj_in) >>> shamt) : (rs_vj_in >> shamt);
            3'b110:  alu_res = rs_vj_in | op_b;
            3'b111:  alu_res = rs_vj_in & op_b;
            default: alu_res = '0;
        endcase
    end

    // Branch condition; the two reserved funct3 codes resolve as not taken
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs_vj_in == rs_vk_in);
            3'b001:  br_taken = (rs_vj_in != rs_vk_in);
            3'b100:  br_taken = ($signed(rs_vj_in) <  $signed(rs_vk_in));
            3'b101:  br_taken = ($signed(rs_vj_in) >= $signed(rs_vk_in));
            3'b110:  br_taken = (rs_vj_in <  rs_vk_in);
            3'b111:  br_taken = (rs_vj_in >= rs_vk_in);
            default: br_taken = 1'b0;
        endcase
    end

    // Result select; unknown opcodes still produce a benign result so the tag is broadcast
    always_comb begin
        nxt_value = '0;
        nxt_pc    = pc_plus4;
        nxt_jump  = 1'b0;
        case (opcode)
            OPC_LUI:    nxt_value = rs_imm_in;
            OPC_AUIPC:  nxt_value = pc_plus_imm;
            OPC_JAL: begin
                nxt_value = pc_plus4;
                nxt_pc    = pc_plus_imm;
                nxt_jump  = 1'b1;
            end
            OPC_JALR: begin
                nxt_value = pc_plus4;
                nxt_pc    = (rs_vj_in + rs_imm_in) & 32'hFFFF_FFFE;
                nxt_jump  = 1'b1;
            end
            OPC_BRANCH: begin
                nxt_pc   = br_taken ? pc_plus_imm : pc_plus4;
                nxt_jump = br_taken;
            end
            OPC_OPIMM,
            OPC_OP:     nxt_value = alu_res;
            default:    nxt_value = '0;
        endcase
    end

    // CDB output registers: flush clears everything, pause holds everything, idle drops valid only
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            alu_broadcast <= 1'b0;
            alu_entry     <= '0;
            alu_value     <= '0;
            alu_pc_out    <= '0;
            alu_jump      <= 1'b0;
        end else if (roll_back) begin
            alu_broadcast <= 1'b0;
            alu_entry     <= '0;
            alu_value     <= '0;
            alu_pc_out    <= '0;
            alu_jump      <= 1'b0;
        end else if (rdy_in) begin
            alu_broadcast <= new_calculate;
            if (new_calculate) begin
                alu_entry  <= rs_entry_in;
                alu_value  <= nxt_value;
                alu_pc_out <= nxt_pc;
                alu_jump   <= nxt_jump;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

    localparam int ENTRY_W = 6;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
    localparam logic [6:0] BR = 7'h63, OPI = 7'h13, OP = 7'h33, LOAD = 7'h03, CUST = 7'h0B;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b1;
    logic               rdy_in = 1'b1;
    logic               roll_back = 1'b0;
    logic               new_calculate = 1'b0;
    logic [31:0]        rs_instruct_in = '0;
    logic [31:0]        rs_vj_in = '0;
    logic [31:0]        rs_vk_in = '0;
    logic [31:0]        rs_imm_in = '0;
    logic [31:0]        rs_pc_in = '0;
    logic [ENTRY_W-1:0] rs_entry_in = '0;
    logic               alu_broadcast;
    logic [ENTRY_W-1:0] alu_entry;
    logic [31:0]        alu_value;
    logic [31:0]        alu_pc_out;
    logic               alu_jump;

    typedef struct {
        logic [ENTRY_W-1:0] entry;
        logic [31:0]        value;
        logic [31:0]        pc_out;
        logic               jump;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk_in = ~clk_in;

    alu_exec_unit #(.ENTRY_W(ENTRY_W)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .roll_back      (roll_back),
        .new_calculate  (new_calculate),
        .rs_instruct_in (rs_instruct_in),
        .rs_vj_in       (rs_vj_in),
        .rs_vk_in       (rs_vk_in),
        .rs_imm_in      (rs_imm_in),
        .rs_pc_in       (rs_pc_in),
        .rs_entry_in    (rs_entry_in),
        .alu_broadcast  (alu_broadcast),
        .alu_entry      (alu_entry),
        .alu_value      (alu_value),
        .alu_pc_out     (alu_pc_out),
        .alu_jump       (alu_jump)
    );

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic b30);
        return {1'b0, b30, 15'b0, f3, 5'b0, op};
    endfunction

    // Drive one issue and record what the CDB must show one edge later
    task automatic issue(input logic [31:0] instr, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [ENTRY_W-1:0] entry,
                         input logic [31:0] ev, input logic [31:0] epc, input logic ej);
        exp_t e;
        rs_instruct_in = instr;
        rs_vj_in       = vj;
        rs_vk_in       = vk;
        rs_imm_in      = imm;
        rs_pc_in       = pc;
        rs_entry_in    = entry;
        new_calculate  = 1'b1;
        e.entry = entry; e.value = ev; e.pc_out = epc; e.jump = ej;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump} !== '0) begin
            failures++;
            $display("FAIL reset_state got bc=%b entry=%0d value=%h pc=%h jump=%b want all 0",
                     alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump);
        end
        @(negedge clk_in) rst_in = 1'b1;
        repeat (2) begin
            @(posedge clk_in); #1;
            checks++;
            if (alu_broadcast !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle_bc got=%b want=0", alu_broadcast);
            end
        end
        // Async reset in the middle of an active broadcast
        issue(mk(OP, 3'b000, 1'b0), 32'd1, 32'd2, 32'd0, 32'h10, 6'd1, 32'd3, 32'h14, 1'b0);
        @(posedge clk_in); #1;
        new_calculate = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (alu_broadcast !== 1'b1 || alu_entry !== e.entry || alu_value !== e.value) begin
            failures++;
            $display("FAIL pre_reset_bc got bc=%b entry=%0d value=%h want bc=1 entry=%0d value=%h",
                     alu_broadcast, alu_entry, alu_value, e.entry, e.value);
        end
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump} !== '0) begin
            failures++;
            $display("FAIL async_reset got bc=%b entry=%0d value=%h pc=%h jump=%b want all 0",
                     alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump);
        end
        @(negedge clk_in) rst_in = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if (alu_broadcast !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_bc got=%b want=0", alu_broadcast);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk_in);
        for (int i = 0; i < 11; i++) begin
            case (i)
                0:  issue(mk(OP, 3'b000, 1'b0), 32'd7, 32'd5, 32'd0, 32'h40, 6'd3, 32'd12, 32'h44, 1'b0);
                1:  issue(mk(OP, 3'b000, 1'b1), 32'd5, 32'd7, 32'd0, 32'h40, 6'd4, 32'hFFFF_FFFE, 32'h44, 1'b0);
                2:  issue(mk(OP, 3'b101, 1'b1), 32'h8000_0000, 32'd4, 32'd0, 32'h40, 6'd5, 32'hF800_0000, 32'h44, 1'b0);
                3:  issue(mk(OP, 3'b101, 1'b0), 32'h8000_0000, 32'd4, 32'd0, 32'h40, 6'd6, 32'h0800_0000, 32'h44, 1'b0);
                4:  issue(mk(OP, 3'b001, 1'b0), 32'd1, 32'h3F, 32'd0, 32'h40, 6'd7, 32'h8000_0000, 32'h44, 1'b0);
                5:  issue(mk(OP, 3'b010, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40, 6'd8, 32'd1, 32'h44, 1'b0);
                6:  issue(mk(OP, 3'b011, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h40, 6'd9, 32'd0, 32'h44, 1'b0);
                7:  issue(mk(OP, 3'b100, 1'b0), 32'hF0F0, 32'h0FF0, 32'd0, 32'h40, 6'd10, 32'hFF00, 32'h44, 1'b0);
                8:  issue(mk(OP, 3'b110, 1'b0), 32'hF000, 32'h000F, 32'd0, 32'h40, 6'd11, 32'hF00F, 32'h44, 1'b0);
                9:  issue(mk(OP, 3'b111, 1'b0), 32'hFF0F, 32'h0FF0, 32'd0, 32'h40, 6'd12, 32'h0F00, 32'h44, 1'b0);
                default: issue(mk(OP, 3'b000, 1'b0), 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h40, 6'd13, 32'd1, 32'h44, 1'b0);
            endcase
            @(posedge clk_in); #1;
            e = exp_q.pop_front();
            checks++;
            if (alu_broadcast !== 1'b1 || alu_entry !== e.entry || alu_value !== e.value ||
                alu_pc_out !== e.pc_out || alu_jump !== e.jump) begin
                failures++;
                $display("FAIL alu_op[%0d] got bc=%b entry=%0d value=%h pc=%h jump=%b want bc=1 entry=%0d value=%h pc=%h jump=%b",
                         i, alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump,
                         e.entry, e.value, e.pc_out, e.jump);
            end
        end
        new_calculate = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (alu_broadcast !== 1'b0 || alu_value !== 32'd1) begin
            failures++;
            $display("FAIL idle_hold got bc=%b value=%h want bc=0 value=00000001", alu_broadcast, alu_value);
        end
    endtask

    task automatic test_imm_compare();
        exp_t e;
        @(negedge clk_in);
        for (int i = 0; i < 10; i++) begin
            case (i)
                0:  issue(mk(OPI, 3'b010, 1'b0), 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h80, 6'd20, 32'd1, 32'h84, 1'b0);
                1:  issue(mk(OPI, 3'b011, 1'b0), 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h80, 6'd21, 32'd0, 32'h84, 1'b0);
                2:  issue(mk(OPI, 3'b101, 1'b0), 32'hF0, 32'd0, 32'd4, 32'h80, 6'd22, 32'h0F, 32'h84, 1'b0);
                3:  issue(mk(OPI, 3'b101, 1'b1), 32'h8000_0000, 32'd0, 32'h404, 32'h80, 6'd23, 32'hF800_0000, 32'h84, 1'b0);
                4:  issue(mk(OPI, 3'b000, 1'b0), 32'd10, 32'd99, 32'hFFFF_FFFD, 32'h80, 6'd24, 32'd7, 32'h84, 1'b0);
                5:  issue(mk(OPI, 3'b001, 1'b0), 32'd3, 32'd0, 32'd2, 32'h80, 6'd25, 32'd12, 32'h84, 1'b0);
                6:  issue(mk(OPI, 3'b100, 1'b0), 32'hFF, 32'd0, 32'hFFFF_FFFF, 32'h80, 6'd26, 32'hFFFF_FF00, 32'h84, 1'b0);
                7:  issue(mk(OPI, 3'b111, 1'b0), 32'h1234, 32'd0, 32'hFF, 32'h80, 6'd27, 32'h34, 32'h84, 1'b0);
                8:  issue(mk(OPI, 3'b110, 1'b0), 32'h1200, 32'd0, 32'h34, 32'h80, 6'd28, 32'h1234, 32'h84, 1'b0);
                default: issue(mk(AUIPC, 3'b000, 1'b0), 32'd0, 32'd0, 32'h2000, 32'h1000, 6'd29, 32'h3000, 32'h1004, 1'b0);
            endcase
            @(posedge clk_in); #1;
            e = exp_q.pop_front();
            checks++;
            if (alu_broadcast !== 1'b1 || alu_entry !== e.entry || alu_value !== e.value ||
                alu_pc_out !== e.pc_out || alu_jump !== e.jump) begin
                failures++;
                $display("FAIL imm_op[%0d] got bc=%b entry=%0d value=%h pc=%h jump=%b want bc=1 entry=%0d value=%h pc=%h jump=%b",
                         i, alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump,
                         e.entry, e.value, e.pc_out, e.jump);
            end
        end
        new_calculate = 1'b0;
    endtask

    task automatic test_control_flow();
        exp_t e;
        @(negedge clk_in);
        for (int i = 0; i < 12; i++) begin
            case (i)
                0:  issue(mk(BR, 3'b100, 1'b0), 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 6'd30, 32'd0, 32'h120, 1'b1);
                1:  issue(mk(BR, 3'b110, 1'b0), 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 6'd31, 32'd0, 32'h104, 1'b0);
                2:  issue(mk(BR, 3'b000, 1'b0), 32'd9, 32'd9, 32'h20, 32'h100, 6'd32, 32'd0, 32'h120, 1'b1);
                3:  issue(mk(BR, 3'b001, 1'b0), 32'd9, 32'd9, 32'h20, 32'h100, 6'd33, 32'd0, 32'h104, 1'b0);
                4:  issue(mk(BR, 3'b101, 1'b0), 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 6'd34, 32'd0, 32'h104, 1'b0);
                5:  issue(mk(BR, 3'b111, 1'b0), 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 6'd35, 32'd0, 32'h120, 1'b1);
                6:  issue(mk(BR, 3'b010, 1'b0), 32'd9, 32'd9, 32'h20, 32'h100, 6'd36, 32'd0, 32'h104, 1'b0);
                7:  issue(mk(JALR, 3'b000, 1'b0), 32'h1001, 32'd0, 32'd2, 32'h200, 6'd37, 32'h204, 32'h1002, 1'b1);
                8:  issue(mk(JAL, 3'b000, 1'b0), 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h200, 6'd38, 32'h204, 32'h1F8, 1'b1);
                9:  issue(mk(LUI, 3'b000, 1'b0), 32'd5, 32'd6, 32'h1234_5000, 32'h200, 6'd39, 32'h1234_5000, 32'h204, 1'b0);
                10: issue(mk(CUST, 3'b000, 1'b0), 32'd5, 32'd6, 32'd7, 32'h200, 6'd40, 32'd0, 32'h204, 1'b0);
                default: issue(mk(LOAD, 3'b010, 1'b0), 32'd5, 32'd6, 32'd7, 32'h200, 6'd41, 32'd0, 32'h204, 1'b0);
            endcase
            @(posedge clk_in); #1;
            e = exp_q.pop_front();
            checks++;
            if (alu_broadcast !== 1'b1 || alu_entry !== e.entry || alu_value !== e.value ||
                alu_pc_out !== e.pc_out || alu_jump !== e.jump) begin
                failures++;
                $display("FAIL ctrl_op[%0d] got bc=%b entry=%0d value=%h pc=%h jump=%b want bc=1 entry=%0d value=%h pc=%h jump=%b",
                         i, alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump,
                         e.entry, e.value, e.pc_out, e.jump);
            end
        end
        new_calculate = 1'b0;
    endtask

    task automatic test_rollback();
        exp_t e;
        @(negedge clk_in);
        issue(mk(OP, 3'b000, 1'b0), 32'd7, 32'd5, 32'd0, 32'h40, 6'd1, 32'd12, 32'h44, 1'b0);
        @(posedge clk_in); #1;
        e = exp_q.pop_front();
        checks++;
        if (alu_broadcast !== 1'b1 || alu_entry !== e.entry || alu_value !== e.value) begin
            failures++;
            $display("FAIL rb_pre got bc=%b entry=%0d value=%h want bc=1 entry=%0d value=%h",
                     alu_broadcast, alu_entry, alu_value, e.entry, e.value);
        end
        // ADD issued alongside the flush must vanish
        rs_entry_in = 6'd2;
        roll_back   = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if ({alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump} !== '0) begin
            failures++;
            $display("FAIL rb_same_cycle got bc=%b entry=%0d value=%h pc=%h jump=%b want all 0",
                     alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump);
        end
        roll_back = 1'b0;
        issue(mk(JAL, 3'b000, 1'b0), 32'd0, 32'd0, 32'h10, 32'h500, 6'd3, 32'h504, 32'h510, 1'b1);
        @(posedge clk_in); #1;
        e = exp_q.pop_front();
        checks++;
        if (alu_broadcast !== 1'b1 || alu_pc_out !== e.pc_out || alu_jump !== e.jump) begin
            failures++;
            $display("FAIL rb_pre2 got bc=%b pc=%h jump=%b want bc=1 pc=%h jump=%b",
                     alu_broadcast, alu_pc_out, alu_jump, e.pc_out, e.jump);
        end
        // Flush wins over a pause
        rdy_in    = 1'b0;
        roll_back = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if ({alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump} !== '0) begin
            failures++;
            $display("FAIL rb_over_pause got bc=%b entry=%0d value=%h pc=%h jump=%b want all 0",
                     alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump);
        end
        roll_back     = 1'b0;
        rdy_in        = 1'b1;
        new_calculate = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (alu_broadcast !== 1'b0) begin
            failures++;
            $display("FAIL rb_after got bc=%b want=0", alu_broadcast);
        end
    endtask

    task automatic test_pause();
        exp_t held;
        exp_t e;
        @(negedge clk_in);
        issue(mk(OP, 3'b000, 1'b0), 32'd100, 32'd23, 32'd0, 32'h300, 6'd9, 32'd123, 32'h304, 1'b0);
        @(posedge clk_in); #1;
        held = exp_q.pop_front();
        checks++;
        if (alu_broadcast !== 1'b1 || alu_entry !== held.entry || alu_value !== held.value ||
            alu_pc_out !== held.pc_out || alu_jump !== held.jump) begin
            failures++;
            $display("FAIL pause_pre got bc=%b entry=%0d value=%h pc=%h want bc=1 entry=%0d value=%h pc=%h",
                     alu_broadcast, alu_entry, alu_value, alu_pc_out, held.entry, held.value, held.pc_out);
        end
        // A different instruction is presented during the pause and must be ignored
        rdy_in         = 1'b0;
        rs_instruct_in = mk(JAL, 3'b000, 1'b0);
        rs_vj_in       = 32'd1;
        rs_vk_in       = 32'd1;
        rs_imm_in      = 32'h40;
        rs_pc_in       = 32'h400;
        rs_entry_in    = 6'd10;
        new_calculate  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_in); #1;
            checks++;
            if (alu_broadcast !== 1'b1 || alu_entry !== held.entry || alu_value !== held.value ||
                alu_pc_out !== held.pc_out || alu_jump !== held.jump) begin
                failures++;
                $display("FAIL pause_hold[%0d] got bc=%b entry=%0d value=%h pc=%h jump=%b want bc=1 entry=%0d value=%h pc=%h jump=0",
                         c, alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump,
                         held.entry, held.value, held.pc_out);
            end
        end
        rdy_in = 1'b1;
        issue(mk(OP, 3'b000, 1'b0), 32'd1, 32'd1, 32'd0, 32'h400, 6'd10, 32'd2, 32'h404, 1'b0);
        @(posedge clk_in); #1;
        e = exp_q.pop_front();
        checks++;
        if (alu_broadcast !== 1'b1 || alu_entry !== e.entry || alu_value !== e.value ||
            alu_pc_out !== e.pc_out || alu_jump !== e.jump) begin
            failures++;
            $display("FAIL pause_resume got bc=%b entry=%0d value=%h pc=%h jump=%b want bc=1 entry=%0d value=%h pc=%h jump=%b",
                     alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump,
                     e.entry, e.value, e.pc_out, e.jump);
        end
        new_calculate = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (alu_broadcast !== 1'b0 || alu_entry !== e.entry || alu_value !== e.value || alu_pc_out !== e.pc_out) begin
            failures++;
            $display("FAIL pause_idle got bc=%b entry=%0d value=%h pc=%h want bc=0 entry=%0d value=%h pc=%h",
                     alu_broadcast, alu_entry, alu_value, alu_pc_out, e.entry, e.value, e.pc_out);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_imm_compare();
        test_control_flow();
        test_rollback();
        test_pause();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
